// File: rtl/apb_timer_unit.sv
// APB-mapped 32-bit timer: prescaled up-counter with a compare match,
// sticky W1C match flag and a level interrupt. Zero wait states.
module apb_timer_unit #(
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq_o
);

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_COUNT  = 12'h004;
    localparam logic [11:0] OFF_CMP    = 12'h008;
    localparam logic [11:0] OFF_STATUS = 12'h00C;

    logic        en_q, en_d;
    logic        autoclr_q, autoclr_d;
    logic        ien_q, ien_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;

    logic        access, mapped, tick, hit;
    logic        sel_ctrl, sel_count, sel_cmp, sel_status;
    logic [11:0] off;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^PADDR[APB_ADDR_WIDTH-1:12];

    always_comb begin
        access     = PSEL & PENABLE;
        off        = PADDR[11:0];
        sel_ctrl   = (off == OFF_CTRL);
        sel_count  = (off == OFF_COUNT);
        sel_cmp    = (off == OFF_CMP);
        sel_status = (off == OFF_STATUS);
        mapped     = sel_ctrl | sel_count | sel_cmp | sel_status;

        PREADY  = 1'b1;
        PSLVERR = ARESETn & access & ~mapped;
        PRDATA  = '0;
        if (ARESETn && access && !PWRITE) begin
            if (sel_ctrl)   PRDATA = {16'h0, presc_q, 5'h0, ien_q, autoclr_q, en_q};
            if (sel_count)  PRDATA = count_q;
            if (sel_cmp)    PRDATA = cmp_q;
            if (sel_status) PRDATA = {31'h0, match_q};
        end
    end

    always_comb begin
        tick = en_q & (pcnt_q == presc_q);
        // Compare always uses the pre-write COUNT and the registered CMP.
        hit  = tick & (count_q == cmp_q);

        en_d      = en_q;
        autoclr_d = autoclr_q;
        ien_d     = ien_q;
        presc_d   = presc_q;
        cmp_d     = cmp_q;
        pcnt_d    = en_q ? (tick ? 8'd0 : pcnt_q + 8'd1) : 8'd0;
        count_d   = tick ? ((hit & autoclr_q) ? 32'd0 : count_q + 32'd1) : count_q;
        match_d   = match_q;

        if (access && PWRITE) begin
            if (sel_ctrl) begin
                en_d      = PWDATA[0];
                autoclr_d = PWDATA[1];
                ien_d     = PWDATA[2];
                presc_d   = PWDATA[15:8];
                if (PWDATA[15:8] != presc_q || !PWDATA[0]) pcnt_d = 8'd0;
            end
            if (sel_count) count_d = PWDATA;
            if (sel_cmp)   cmp_d   = PWDATA;
            if (sel_status && PWDATA[0]) match_d = 1'b0;
        end
        // A match in the same cycle wins over the W1C clear.
        if (hit) match_d = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            en_q      <= 1'b0;
            autoclr_q <= 1'b0;
            ien_q     <= 1'b0;
            presc_q   <= 8'd0;
            pcnt_q    <= 8'd0;
            count_q   <= 32'd0;
            cmp_q     <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
        end else begin
            en_q      <= en_d;
            autoclr_q <= autoclr_d;
            ien_q     <= ien_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
        end
    end

    assign irq_o = match_q & ien_q;

endmodule

// File: tb/tb_apb_timer_unit.sv
// Randomized + directed bench for apb_timer_unit; expected responses come
// from a behavioural model and are checked by a decoupled monitor.
module tb_apb_timer_unit;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        PSEL = 1'b1;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;
    exp_t sb[$];

    // Behavioural model state
    bit          m_en, m_ac, m_ien, m_match;
    logic [7:0]  m_presc;
    logic [31:0] m_count, m_cmp;
    int unsigned m_ph;

    apb_timer_unit #(.APB_ADDR_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ac = 0; m_ien = 0; m_match = 0;
        m_presc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_ph = 0;
    endtask

    function automatic bit is_mapped(input logic [11:0] o);
        return (o == 12'h000) || (o == 12'h004) || (o == 12'h008) || (o == 12'h00C);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] o);
        case (o)
            12'h000: return {16'h0, m_presc, 5'h0, m_ien, m_ac, m_en};
            12'h004: return m_count;
            12'h008: return m_cmp;
            12'h00C: return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the timer, seen from its rules: a tick every
    // PRESC+1 enabled cycles, phase restarted by prescaler-affecting writes.
    task automatic model_update();
        bit          wr, tick, hit, nmatch;
        logic [11:0] o;
        logic [31:0] ncount;
        wr   = PSEL && PENABLE && PWRITE;
        o    = PADDR[11:0];
        tick = 0;
        if (m_en) begin
            tick = (m_ph % (int'(m_presc) + 1)) == int'(m_presc);
            m_ph++;
        end else begin
            m_ph = 0;
        end
        hit    = tick && (m_count == m_cmp);
        ncount = m_count;
        nmatch = m_match;
        if (tick) ncount = (hit && m_ac) ? 32'h0 : m_count + 32'h1;
        if (hit) nmatch = 1;
        if (wr) begin
            case (o)
                12'h000: begin
                    if (PWDATA[15:8] != m_presc || !PWDATA[0]) m_ph = 0;
                    m_en = PWDATA[0]; m_ac = PWDATA[1]; m_ien = PWDATA[2];
                    m_presc = PWDATA[15:8];
                end
                12'h004: ncount = PWDATA;
                12'h008: m_cmp = PWDATA;
                12'h00C: if (PWDATA[0] && !hit) nmatch = 0;
                default: ;
            endcase
        end
        m_count = ncount;
        m_match = nmatch;
    endtask

    task automatic step();
        @(posedge ACLK);
        if (ARESETn) model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        PADDR = addr; PWRITE = wr; PWDATA = data; PENABLE = 0;
        step();
        PENABLE = 1;
        e.slverr = !is_mapped(addr[11:0]);
        e.rdata  = wr ? 32'h0 : model_read(addr[11:0]);
        sb.push_back(e);
        step();
        PENABLE = 0; PWRITE = 0;
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #3;
        ARESETn = 0; PENABLE = 0; PWRITE = 0;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1;
    endtask

    // Monitor: compares every cycle; pops an expectation on each access.
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            chk("pready", {31'h0, PREADY}, 32'h1);
            chk("irq_o", {31'h0, irq_o}, {31'h0, m_match & m_ien});
            if (ARESETn && PSEL && PENABLE) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: access at %0t with no expectation", $time);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("prdata @%0h", PADDR), PRDATA, e.rdata);
                    chk($sformatf("pslverr @%0h", PADDR), {31'h0, PSLVERR}, {31'h0, e.slverr});
                end
            end else begin
                chk("prdata idle", PRDATA, 32'h0);
                chk("pslverr idle", {31'h0, PSLVERR}, 32'h0);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a, d;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1;

        // Reset values of every register
        apb(0, 32'h000, 0); apb(0, 32'h004, 0); apb(0, 32'h008, 0); apb(0, 32'h00C, 0);

        // Auto-clear at CMP=3, every-cycle tick
        apb(1, 32'h008, 3);
        apb(1, 32'h000, 32'h0000_0007);
        for (int i = 0; i < 6; i++) apb(0, 32'h004, 0);
        apb(0, 32'h00C, 0);

        // W1C landing on a match tick: match must survive
        apb(1, 32'h00C, 1);
        n = 0;
        while (m_count != m_cmp - 32'h1 && n < 50) begin step(); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL align: never reached pre-match count, got %h", m_count);
        end
        apb(1, 32'h00C, 1);
        apb(0, 32'h00C, 0);
        apb(1, 32'h000, 32'h0000_0004);
        apb(1, 32'h00C, 1);
        apb(0, 32'h00C, 0);

        // Prescale 4: one tick every 5 cycles, freeze on EN clear
        apb(1, 32'h004, 0);
        apb(1, 32'h008, 32'hFFFF_FFFF);
        apb(1, 32'h000, 32'h0000_0401);
        for (int i = 0; i < 8; i++) begin apb(0, 32'h004, 0); idle(i % 3); end
        apb(1, 32'h000, 32'h0000_0400);
        apb(0, 32'h004, 0); idle(7); apb(0, 32'h004, 0);
        apb(1, 32'h000, 32'h0000_0401);
        for (int i = 0; i < 4; i++) apb(0, 32'h004, 0);

        // Wrap at 0xFFFFFFFF without a match
        apb(1, 32'h000, 0);
        apb(1, 32'h00C, 1);
        apb(1, 32'h004, 32'hFFFF_FFFF);
        apb(1, 32'h008, 5);
        apb(1, 32'h000, 32'h0000_0001);
        apb(0, 32'h004, 0); apb(0, 32'h00C, 0);

        // Unmapped offsets: error, zero data, no state change
        apb(1, 32'h000, 0);
        apb(1, 32'h010, 32'hFFFF_FFFF); apb(0, 32'h010, 0);
        apb(1, 32'hFFC, 32'h1234_5678); apb(0, 32'hFFC, 0);
        apb(0, 32'h000, 0); apb(0, 32'h004, 0); apb(0, 32'h008, 0); apb(0, 32'h00C, 0);

        // Reset mid-count discards everything
        apb(1, 32'h000, 32'h0000_0007);
        idle(5);
        do_reset();
        idle(3);
        apb(0, 32'h000, 0); apb(0, 32'h004, 0); apb(0, 32'h008, 0); apb(0, 32'h00C, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h000;
                1: a = 32'h004;
                2: a = 32'h008;
                3: a = 32'h00C;
                4: a = 32'h010;
                5: a = 32'hFFC;
                6: a = $urandom;
                default: a = {$urandom_range(0, 15), 28'h0} | 32'(4 * $urandom_range(0, 3));
            endcase
            case (a[11:0])
                12'h000: d = ($urandom & 32'hFFFF_00F8) | 32'($urandom_range(0, 7))
                             | {16'h0, 8'($urandom_range(0, 3)), 8'h0}
                             & 32'hFFFF_03FF;
                12'h004, 12'h008: d = 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            apb($urandom_range(0, 1) == 1, a, d);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_timer_unit.md
APB_TIMER_UNIT -- requirements
Module: apb_timer_unit

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, the PADDR width.
REQ-002 SHALL have ACLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have PSEL  input  1  slave select; the upstream bridge ties it to 1.
REQ-005 SHALL have PENABLE  input  1  access cycle active.
REQ-006 SHALL have PWRITE  input  1  1 = write, 0 = read.
REQ-007 SHALL have PADDR  input  APB_ADDR_WIDTH  byte address; only bits [11:0] are decoded.
REQ-008 SHALL have PWDATA  input  32  write data, always a full word (no strobes).
REQ-009 SHALL have PRDATA  output  32  read data.
REQ-010 SHALL have PREADY  output  1  transfer complete.
REQ-011 SHALL have PSLVERR  output  1  error response.
REQ-012 SHALL have irq_o  output  1  level interrupt.

Function
REQ-013 SHALL define access = PSEL & PENABLE; a write commits on the rising edge where access & PWRITE; a read is sampled by the master in the same cycle.
REQ-014 SHALL drive PREADY = 1 constantly (zero wait states), so each access cycle is exactly one transfer.
REQ-015 SHALL decode PADDR[11:0] as follows: 0x000 CTRL, 0x004 COUNT, 0x008 CMP, 0x00C STATUS. Any other offset is unmapped.
REQ-016 SHALL handle an unmapped access as follows: PSLVERR = 1 combinationally during access, PRDATA = 0, no state change. PSLVERR SHALL be 0 otherwise.
REQ-017 SHALL drive PRDATA combinationally with the addressed register during a read access, and 0 at all other times.
REQ-018 SHALL lay out CTRL as: bit0 EN, bit1 AUTOCLR, bit2 IEN, bits[15:8] PRESC. Other bits SHALL be write-ignored and read 0.
REQ-019 SHALL lay out STATUS as: bit0 MATCH, sticky. Writing 1 SHALL clear it; writing 0 SHALL have no effect. Other bits SHALL read 0.
REQ-020 SHALL keep an internal 8-bit prescale counter PCNT. While EN = 1: if PCNT == PRESC, then PCNT <= 0 and tick = 1; otherwise PCNT <= PCNT + 1 and tick = 0. While EN = 0: PCNT holds 0 and there is no tick.
REQ-021 SHALL apply PRESC = 0 as one tick every cycle, and PRESC = N as one tick every N+1 cycles.
REQ-022 SHALL update COUNT on a tick as follows: if COUNT == CMP, set MATCH and COUNT <= (AUTOCLR ? 0 : COUNT + 1). Otherwise COUNT <= COUNT + 1. Increment SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0).
REQ-023 SHALL give a software write to COUNT priority over a same-cycle tick: COUNT <= PWDATA. The match compare in that cycle SHALL still use the old COUNT.
REQ-024 SHALL reset PCNT to 0 on the next edge when a CTRL write changes PRESC or clears EN.
REQ-025 SHALL give a MATCH set priority over a same-cycle W1C clear (flag stays 1).
REQ-026 SHALL apply a CMP write from the next cycle; the compare SHALL use the registered CMP value.
REQ-027 SHALL drive irq_o = MATCH & IEN from registers only (glitch-free); clearing IEN SHALL drop irq_o without clearing MATCH.

Reset
REQ-028 SHALL, while ARESETn = 0 (asynchronously): CTRL = 0, COUNT = 0, CMP = 0xFFFFFFFF, MATCH = 0, PCNT = 0.
REQ-029 SHALL drive outputs during reset to: irq_o = 0, PSLVERR = 0, PRDATA = 0, PREADY = 1.
REQ-030 SHALL, on reset mid-count, discard all state; counting SHALL resume only after software sets EN.

Verification
REQ-031 SHALL cover: reset, then read each offset 0x000/0x004/0x008/0x00C -> 0x0, 0x0, 0xFFFFFFFF, 0x0; PSLVERR = 0.
REQ-032 SHALL cover: CMP = 3, CTRL = 0x0000_0007 (PRESC 0, EN, AUTOCLR, IEN) -> COUNT sequence 0,1,2,3,0; MATCH and irq_o rise 1 cycle after COUNT = 3 is observed.
REQ-033 SHALL cover: CTRL with PRESC = 4 and EN -> COUNT increments exactly once every 5 cycles; clearing EN freezes COUNT and zeroes PCNT.
REQ-034 SHALL cover: COUNT = 0xFFFFFFFF, CMP = 5, EN, AUTOCLR = 0 -> next tick gives COUNT = 0, MATCH stays 0.
REQ-035 SHALL cover: W1C of STATUS landing in the same cycle as a match tick -> MATCH = 1; a following STATUS write of 0x1 -> MATCH = 0, irq_o = 0.
REQ-036 SHALL cover: read and write to offset 0x010 and 0xFFC -> PSLVERR = 1, PRDATA = 0, all registers unchanged.
